mem_responder: RTL
==================

# mem_responder

Multi-cycle word memory that sits at the far end of the memory-stage data port. It accepts one read or write request at a time from the pipeline and holds the requester with `Stall` while the access is in flight. It returns `DataOut` with a one-cycle `Done` pulse and flags illegal requests on `Err`. An optional one-entry read hit buffer completes repeated reads in zero cycles and reports them on `CacheHit`.

## Interface
- `LATENCY`, default 4: cycles from accept to `Done`; legal range ≥1.
- `ADDR_W`, default 12: word-index bits; array depth is 2^ADDR_W 16-bit words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Rd`  in  1  read request.
- `Wr`  in  1  write request.
- `Addr`  in  16  byte address. Word index is `Addr[ADDR_W:1]`; upper bits are ignored, so addresses alias.
- `DataIn`  in  16  write data.
- `DataOut`  out  16  read data; valid while `Done`=1 on a read.
- `Done`  out  1  one-cycle completion pulse.
- `Stall`  out  1  requester must hold its request and stall.
- `CacheHit`  out  1  completion was served by the hit buffer.
- `Err`  out  1  illegal request this cycle.

## Operation
- FSM states are IDLE and BUSY, plus a down-counter of width clog2(LATENCY+1).
- A request is present when `Rd|Wr`=1. It is illegal when `Rd&Wr`=1 or `Addr[0]`=1.
- **IDLE, no request:**
  - `Stall`=`Done`=`Err`=`CacheHit`=0.
- **IDLE, illegal request:**
  - `Err`=1 combinationally in the same cycle; `Stall`=0, `Done`=0.
  - No array access and no state change.
- **IDLE, legal request:**
  - Capture op, word index and `DataIn`.
  - Load counter with LATENCY-1 and go to BUSY.
  - `Stall`=1 in the accept cycle.
- **BUSY:**
  - `Stall`=1 while counter ≠0; decrement each cycle.
  - The requester's inputs are ignored; the captured copy is authoritative.
- **Completion (counter=0 in BUSY):**
  - `Done`=1, `Stall`=0, return to IDLE next edge.
  - Read: `DataOut` = array[captured index].
  - Write: array written at this edge; `DataOut` holds its previous value.
- A request still asserted in IDLE after `Done` is a new request. The requester must advance or drop it.
- `DataOut` updates only on read completion and otherwise holds.
- **Reset:**
  - `rst`=0 at any time, including mid-BUSY, forces IDLE and clears the counter.
  - `DataOut`=0, `Done`=`Stall`=`CacheHit`=`Err`=0.
  - A pending write is discarded; array contents are not reset.

## Timing
- Accept in cycle T; `Done` in cycle T+LATENCY; `Stall`=1 in cycles T..T+LATENCY-1.
- LATENCY=1: `Stall` is high only in T, and `Done` is in T+1.
- Earliest next accept is T+LATENCY+1.
- `Err` and `Stall` are combinational from state and inputs. `DataOut`, `Done` and `CacheHit` are registered/state-derived.

## Configuration
- `MEM_RESP_HITBUF_EN` defined:
  - One-entry buffer holds a valid bit, word index and data of the last completed read.
  - IDLE read with valid and matching index: `Done`=1, `CacheHit`=1 and `DataOut`=buffer data in the same cycle (combinational path), `Stall`=0, no BUSY.
  - Writes still take LATENCY. On write completion, a matching buffer entry is updated (write-through).
  - Reset clears the valid bit.
- `MEM_RESP_HITBUF_EN` undefined:
  - `CacheHit` is tied 0.
  - Every legal access takes LATENCY.

## Structure
- Shared package/include `mem_resp_pkg`: state encoding (IDLE, BUSY) and `WORD_W`=16.
- One sub-module `mem_array`: single-port 2^ADDR_W×16 array with asynchronous read and synchronous write on a write-enable. It has no reset.

## Test plan
- Reset, then Wr 0x1234 to 0x0010 (LATENCY=4) -> `Stall`=1 in T..T+3, `Done`=1 only in T+4, `Err`=0.
- Rd 0x0010 after the write -> `Done` at T+4 with `DataOut`=0x1234. With `MEM_RESP_HITBUF_EN`, an immediate second Rd 0x0010 -> `Done`=1, `CacheHit`=1, `DataOut`=0x1234, `Stall`=0 in the request cycle.
- Rd 0x0011 in IDLE -> `Err`=1 that cycle, `Stall`=0, `Done`=0, still IDLE. `Rd`=`Wr`=1 at 0x0010 -> `Err`=1, no array change.
- Wr 0xBEEF to 0x0020 (prior content 0x0000), `rst`=0 in the second BUSY cycle -> all outputs 0 immediately. A later Rd 0x0020 returns 0x0000.
- ADDR_W=12: Wr 0x5A5A to 0x2002, then Rd 0x0002 -> `DataOut`=0x5A5A (alias).
- LATENCY=1 back-to-back Wr 0x0004, then Rd 0x0004 -> `Done` in T+1 and T+3, read returns the written data.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_responder slice.
// Holds the FSM state encoding, the word width and the request legality check.
package mem_resp_pkg;

  localparam int WORD_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // A request is illegal if it asks for both operations or uses an odd byte address.
  function automatic logic request_illegal(input logic rd, input logic wr, input logic a0);
    return (rd | wr) & ((rd & wr) | a0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array for mem_responder.
// Reads are asynchronous, writes are synchronous on we, and there is no reset.
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle word memory responder with Stall/Done handshake and Err reporting.
// The optional one-entry read hit buffer is enabled by defining MEM_RESP_HITBUF_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [15:0]       Addr,
  input  logic [WORD_W-1:0] DataIn,
  output logic [WORD_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              Err
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  op_t               op_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic [WORD_W-1:0] dout_reg;
  logic [WORD_W-1:0] mem_rdata;

  logic [ADDR_W-1:0] addr_idx;
  logic              req;
  logic              illegal;
  logic              legal;
  logic              complete;
  logic              accept;
  logic              hit;
  logic              mem_we;
  logic [WORD_W-1:0] hit_data;

  // Byte address bits above the word index alias and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr[15:ADDR_W+1];

  assign addr_idx = Addr[ADDR_W:1];
  assign req      = Rd | Wr;
  assign illegal  = request_illegal(Rd, Wr, Addr[0]);
  assign legal    = req & ~illegal;
  assign complete = (state_reg == BUSY) && (cnt_reg == '0);
  assign accept   = (state_reg == IDLE) && legal && !hit;
  assign mem_we   = complete && (op_reg == OP_WR);

`ifdef MEM_RESP_HITBUF_EN
  logic              hb_valid_reg;
  logic [ADDR_W-1:0] hb_idx_reg;
  logic [WORD_W-1:0] hb_data_reg;

  assign hit      = (state_reg == IDLE) && legal && Rd && hb_valid_reg && (hb_idx_reg == addr_idx);
  assign hit_data = hb_data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hb_valid_reg <= 1'b0;
      hb_idx_reg   <= '0;
      hb_data_reg  <= '0;
    end else if (complete) begin
      if (op_reg == OP_RD) begin
        hb_valid_reg <= 1'b1;
        hb_idx_reg   <= idx_reg;
        hb_data_reg  <= mem_rdata;
      end else if (hb_valid_reg && (hb_idx_reg == idx_reg)) begin
        // Write-through keeps the buffered copy coherent with the array.
        hb_data_reg <= wdata_reg;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (idx_reg),
    .wdata(wdata_reg),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_RD;
      idx_reg   <= '0;
      wdata_reg <= '0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        op_reg    <= Wr ? OP_WR : OP_RD;
        idx_reg   <= addr_idx;
        wdata_reg <= DataIn;
      end
      if (complete && (op_reg == OP_RD)) begin
        dout_reg <= mem_rdata;
      end else if (hit) begin
        dout_reg <= hit_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    Stall      = 1'b0;
    Err        = 1'b0;
    Done       = 1'b0;
    CacheHit   = 1'b0;
    DataOut    = dout_reg;
    case (state_reg)
      IDLE: begin
        Err = rst & illegal;
        if (accept) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
          Stall      = rst;
        end
        if (hit) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          DataOut  = hit_data;
        end
      end
      BUSY: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
          Done       = 1'b1;
          // The array is stable during BUSY, so the async read is valid in the completion cycle.
          if (op_reg == OP_RD) begin
            DataOut = mem_rdata;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
          Stall    = rst;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
